vga_layer_mixer: RTL and testbench

- Frame-side counterpart of the sprite layers: generates 640x480@60 VGA timing and drives req_x/req_y pixel requests plus the active-low v_sync frame clear to every layer.
- Collects each layer's rgb/alpha one cycle later and composites them by fixed priority over a background colour.
- Drives the registered VGA pins.
- Sits at the top level between all sprite/background layers and the board VGA connector.

---
 rtl/vga_layer_mixer_pkg.sv | 36 +++
 rtl/vga_timing_gen.sv | 74 +++++++
 rtl/vga_layer_mixer.sv | 196 +++++++++++++++++++
 tb/tb_vga_layer_mixer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_layer_mixer_pkg.sv
// Shared constants for the VGA layer mixer: 640x480@60 timing, address and
// colour widths, and the colour-bar helper used by the optional test pattern.
package vga_layer_mixer_pkg;

    localparam int H_DISP          = 640;
    localparam int H_FP            = 16;
    localparam int H_SYNC          = 96;
    localparam int H_BP            = 48;
    localparam int H_TOTAL         = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_DISP          = 480;
    localparam int V_FP            = 10;
    localparam int V_SYNC          = 2;
    localparam int V_BP            = 33;
    localparam int V_TOTAL         = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int H_DISP_LEN      = 10;
    localparam int V_DISP_LEN      = 10;
    localparam int COLOR_RGB_DEPTH = 12;

    // Counters share the address width; a 1024-wide space covers both totals.
    localparam int CNT_W      = H_DISP_LEN;
    localparam int COLOR_CH_W = COLOR_RGB_DEPTH / 3;
    localparam int TP_BARS    = 8;

    // Bar order white, yellow, cyan, green, magenta, red, blue, black:
    // each channel is on when the matching index bit is clear.
    function automatic logic [COLOR_RGB_DEPTH-1:0] bar_rgb(input logic [2:0] bar);
        logic r_s;
        logic g_s;
        logic b_s;
        r_s = ~bar[1];
        g_s = ~bar[2];
        b_s = ~bar[0];
        return {{COLOR_CH_W{r_s}}, {COLOR_CH_W{g_s}}, {COLOR_CH_W{b_s}}};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical pixel counters and the raw (undelayed) timing decodes:
// visible flags, active-low syncs and the frame-start marker at (0,0).
module vga_timing_gen
    import vga_layer_mixer_pkg::*;
#(
    parameter int H_DISP = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_DISP = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic             clk_vga,
    input  logic             rst,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             h_vis,
    output logic             v_vis,
    output logic             de_raw,
    output logic             hs_raw,
    output logic             vs_raw,
    output logic             frame_start_raw
);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_DISP + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_DISP + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_DISP);
    localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_DISP);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_DISP + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_DISP + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_DISP + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_DISP + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt_r;
    logic [CNT_W-1:0] v_cnt_r;

    // Pixel/line counters; h and v wrap together on the last pixel of the frame.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            h_cnt_r <= {CNT_W{1'b0}};
            v_cnt_r <= {CNT_W{1'b0}};
        end else if (h_cnt_r == H_LAST) begin
            h_cnt_r <= {CNT_W{1'b0}};
            if (v_cnt_r == V_LAST) begin
                v_cnt_r <= {CNT_W{1'b0}};
            end else begin
                v_cnt_r <= v_cnt_r + 10'd1;
            end
        end else begin
            h_cnt_r <= h_cnt_r + 10'd1;
        end
    end

    // Raw timing decodes straight from the counter state.
    always_comb begin
        h_vis           = 1'b0;
        v_vis           = 1'b0;
        hs_raw          = 1'b1;
        vs_raw          = 1'b1;
        frame_start_raw = 1'b0;
        h_vis           = (h_cnt_r < H_VIS_END);
        v_vis           = (v_cnt_r < V_VIS_END);
        hs_raw          = ~((h_cnt_r >= HS_START) && (h_cnt_r < HS_END));
        vs_raw          = ~((v_cnt_r >= VS_START) && (v_cnt_r < VS_END));
        frame_start_raw = (h_cnt_r == {CNT_W{1'b0}}) && (v_cnt_r == {CNT_W{1'b0}});
    end

    assign h_cnt  = h_cnt_r;
    assign v_cnt  = v_cnt_r;
    assign de_raw = h_vis & v_vis;

endmodule

// File: rtl/vga_layer_mixer.sv
// Frame-side VGA mixer: issues pixel requests to every layer, captures the
// layers' rgb/alpha one cycle later, composites them by fixed priority
// (layer 0 on top) over a background and drives the registered VGA pins.
// Pins lag the request stage by exactly two clocks.
// Optional build macro VGA_TEST_PATTERN_EN replaces the background with
// eight vertical colour bars selected from the delayed request column.
module vga_layer_mixer
    import vga_layer_mixer_pkg::*;
#(
    parameter int H_DISP = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_DISP = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int LAYERS = 4,
    parameter int RGB_W  = COLOR_RGB_DEPTH
) (
    input  logic                    clk_vga,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic [RGB_W-1:0]        bg_rgb_i,
    input  logic [LAYERS*RGB_W-1:0] layer_rgb_i,
    input  logic [LAYERS-1:0]       layer_alpha_i,
    output logic [H_DISP_LEN-1:0]   req_x_addr_o,
    output logic [V_DISP_LEN-1:0]   req_y_addr_o,
    output logic                    v_sync_o,
    output logic                    frame_start_o,
    output logic                    vga_hs_o,
    output logic                    vga_vs_o,
    output logic                    vga_de_o,
    output logic [RGB_W-1:0]        vga_rgb_o
);

    logic [CNT_W-1:0] h_cnt_s;
    logic [CNT_W-1:0] v_cnt_s;
    logic             h_vis_s;
    logic             v_vis_s;
    logic             de_raw_s;
    logic             hs_raw_s;
    logic             vs_raw_s;
    logic             frame_start_raw_s;

    // Stage 0: request registers
    logic [H_DISP_LEN-1:0] req_x_r;
    logic [V_DISP_LEN-1:0] req_y_r;
    logic                  v_sync_r;
    logic                  frame_start_r;
    logic                  hs_s0_r;
    logic                  de_s0_r;

    // Stage 1: timing aligned with the layer read data
    logic                  de_d1_r;
    logic                  hs_d1_r;
    logic                  vs_d1_r;

    // Stage 2: pin registers
    logic                  pin_hs_r;
    logic                  pin_vs_r;
    logic                  pin_de_r;
    logic [RGB_W-1:0]      pin_rgb_r;

    logic                  layer_hit_s;
    logic [RGB_W-1:0]      layer_pick_s;
    logic [RGB_W-1:0]      bg_s;
    logic [RGB_W-1:0]      pixel_s;

    vga_timing_gen #(
        .H_DISP (H_DISP),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_DISP (V_DISP),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .clk_vga         (clk_vga),
        .rst             (rst),
        .h_cnt           (h_cnt_s),
        .v_cnt           (v_cnt_s),
        .h_vis           (h_vis_s),
        .v_vis           (v_vis_s),
        .de_raw          (de_raw_s),
        .hs_raw          (hs_raw_s),
        .vs_raw          (vs_raw_s),
        .frame_start_raw (frame_start_raw_s)
    );

    // Stage 0: register the request; blanking addresses park at all-ones so
    // no layer ever matches and their BRAM counters hold.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            req_x_r       <= {H_DISP_LEN{1'b0}};
            req_y_r       <= {V_DISP_LEN{1'b0}};
            v_sync_r      <= 1'b1;
            frame_start_r <= 1'b0;
            hs_s0_r       <= 1'b1;
            de_s0_r       <= 1'b0;
        end else begin
            req_x_r       <= h_vis_s ? h_cnt_s : {H_DISP_LEN{1'b1}};
            req_y_r       <= v_vis_s ? v_cnt_s : {V_DISP_LEN{1'b1}};
            v_sync_r      <= vs_raw_s;
            frame_start_r <= frame_start_raw_s;
            hs_s0_r       <= hs_raw_s;
            de_s0_r       <= de_raw_s;
        end
    end

    // Stage 1: delay timing by the layers' one-cycle read latency.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            de_d1_r <= 1'b0;
            hs_d1_r <= 1'b1;
            vs_d1_r <= 1'b1;
        end else begin
            de_d1_r <= de_s0_r;
            hs_d1_r <= hs_s0_r;
            vs_d1_r <= v_sync_r;
        end
    end

    // Priority pick: walk from the lowest-priority layer up so layer 0 wins.
    always_comb begin
        layer_hit_s  = 1'b0;
        layer_pick_s = {RGB_W{1'b0}};
        for (int k = LAYERS - 1; k >= 0; k--) begin
            layer_pick_s = layer_alpha_i[k] ? layer_rgb_i[k*RGB_W +: RGB_W] : layer_pick_s;
            layer_hit_s  = layer_hit_s | layer_alpha_i[k];
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_DISP / TP_BARS;

    logic [H_DISP_LEN-1:0] x_d1_r;
    logic [2:0]            bar_idx_s;

    // Delayed column so the bar lines up with the layer data of the same pixel.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            x_d1_r <= {H_DISP_LEN{1'b0}};
        end else begin
            x_d1_r <= req_x_r;
        end
    end

    // Bar index by threshold compare, avoiding a divider.
    always_comb begin
        bar_idx_s = 3'd0;
        for (int i = 1; i < TP_BARS; i++) begin
            bar_idx_s = (x_d1_r >= H_DISP_LEN'(i * BAR_W)) ? 3'(i) : bar_idx_s;
        end
        bg_s = RGB_W'(bar_rgb(bar_idx_s));
    end
`else
    assign bg_s = bg_rgb_i;
`endif

    // Final colour: blank outside the visible area or while display is off.
    always_comb begin
        pixel_s = {RGB_W{1'b0}};
        if (de_d1_r && en_i) begin
            pixel_s = layer_hit_s ? layer_pick_s : bg_s;
        end else begin
            pixel_s = {RGB_W{1'b0}};
        end
    end

    // Stage 2: pin registers; syncs travel with the colour they belong to.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            pin_hs_r  <= 1'b1;
            pin_vs_r  <= 1'b1;
            pin_de_r  <= 1'b0;
            pin_rgb_r <= {RGB_W{1'b0}};
        end else begin
            pin_hs_r  <= hs_d1_r;
            pin_vs_r  <= vs_d1_r;
            pin_de_r  <= de_d1_r;
            pin_rgb_r <= pixel_s;
        end
    end

    assign req_x_addr_o  = req_x_r;
    assign req_y_addr_o  = req_y_r;
    assign v_sync_o      = v_sync_r;
    assign frame_start_o = frame_start_r;
    assign vga_hs_o      = pin_hs_r;
    assign vga_vs_o      = pin_vs_r;
    assign vga_de_o      = pin_de_r;
    assign vga_rgb_o     = pin_rgb_r;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Self-checking bench for vga_layer_mixer. A full-size instance is checked
// cycle by cycle against a scoreboard; a small-timing instance covers whole
// frames, counter wraps and sync pulse counts within a short run.
module tb_vga_layer_mixer;

    localparam int RW = 12;
    localparam int NL = 4;

    // small-timing instance geometry
    localparam int SH_DISP = 16, SH_FP = 2, SH_SYNC = 3, SH_BP = 3;
    localparam int SV_DISP = 6,  SV_FP = 2, SV_SYNC = 2, SV_BP = 2;
    localparam int SH_TOT  = SH_DISP + SH_FP + SH_SYNC + SH_BP;
    localparam int SV_TOT  = SV_DISP + SV_FP + SV_SYNC + SV_BP;

    logic             clk_vga = 1'b0;
    logic             rst;
    logic             en_i;
    logic [RW-1:0]    bg_rgb_i;
    logic [NL*RW-1:0] layer_rgb_i;
    logic [NL-1:0]    layer_alpha_i;
    logic [9:0]       req_x_addr_o, req_y_addr_o;
    logic             v_sync_o, frame_start_o, vga_hs_o, vga_vs_o, vga_de_o;
    logic [RW-1:0]    vga_rgb_o;

    logic [NL*RW-1:0] s_layer_rgb = '0;
    logic [NL-1:0]    s_layer_alpha = '0;
    logic [9:0]       s_req_x, s_req_y;
    logic             s_v_sync, s_frame_start, s_hs, s_vs, s_de;
    logic [RW-1:0]    s_rgb;

    always #20 clk_vga = ~clk_vga;

    vga_layer_mixer dut (
        .clk_vga(clk_vga), .rst(rst), .en_i(en_i), .bg_rgb_i(bg_rgb_i),
        .layer_rgb_i(layer_rgb_i), .layer_alpha_i(layer_alpha_i),
        .req_x_addr_o(req_x_addr_o), .req_y_addr_o(req_y_addr_o),
        .v_sync_o(v_sync_o), .frame_start_o(frame_start_o),
        .vga_hs_o(vga_hs_o), .vga_vs_o(vga_vs_o), .vga_de_o(vga_de_o),
        .vga_rgb_o(vga_rgb_o)
    );

    vga_layer_mixer #(
        .H_DISP(SH_DISP), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
        .V_DISP(SV_DISP), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
    ) dut_small (
        .clk_vga(clk_vga), .rst(rst), .en_i(en_i), .bg_rgb_i(bg_rgb_i),
        .layer_rgb_i(s_layer_rgb), .layer_alpha_i(s_layer_alpha),
        .req_x_addr_o(s_req_x), .req_y_addr_o(s_req_y),
        .v_sync_o(s_v_sync), .frame_start_o(s_frame_start),
        .vga_hs_o(s_hs), .vga_vs_o(s_vs), .vga_de_o(s_de),
        .vga_rgb_o(s_rgb)
    );

    typedef struct {
        logic          de;
        logic          hs;
        logic          vs;
        logic          hit;
        logic [RW-1:0] lrgb;
        int            x;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int cyc;
    int mh, mv, sh, sv;
    int fs_cyc, hs_fall_cyc;
    logic prev_hs;
    int hs_low_cnt, de_hi_cnt, rgb_nz_cnt;
    int s_hs_low, s_vs_low, s_de_hi, s_fs_cnt;

    // layer configuration; a layer either returns its column or a fixed colour
    logic          cfg_use_x;
    logic [RW-1:0] cfg_rgb [NL];
    logic [NL-1:0] cfg_alpha;
    logic [NL*RW-1:0] pend_rgb;
    logic [NL-1:0]    pend_alpha;

    function automatic logic [RW-1:0] bar_color(input int x);
        case (x / 80)
            0: return 12'hFFF;
            1: return 12'hFF0;
            2: return 12'h0FF;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'hF00;
            6: return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    // one pixel clock: layer model answers, stage-0 model check, scoreboard
    task automatic step();
        exp_t          e;
        exp_t          p;
        logic [9:0]    ex, ey, sx, sy;
        logic [RW-1:0] lr [NL];
        logic [RW-1:0] exp_rgb;
        logic [RW-1:0] bgv;
        @(posedge clk_vga);
        #1;
        layer_rgb_i   = pend_rgb;
        layer_alpha_i = pend_alpha;
        cyc++;
        @(negedge clk_vga);
        // stage 0 of the full-size instance
        ex = (mh < 640) ? 10'(mh) : 10'h3FF;
        ey = (mv < 480) ? 10'(mv) : 10'h3FF;
        checks++;
        if ({req_x_addr_o, req_y_addr_o, v_sync_o, frame_start_o} !==
            {ex, ey, !(mv >= 490 && mv < 492), (mh == 0 && mv == 0)}) begin
            errors++;
            $display("FAIL stage0 cyc=%0d got x=%0d y=%0d vs=%b fs=%b want x=%0d y=%0d vs=%b fs=%b",
                cyc, req_x_addr_o, req_y_addr_o, v_sync_o, frame_start_o,
                ex, ey, !(mv >= 490 && mv < 492), (mh == 0 && mv == 0));
        end
        if (frame_start_o === 1'b1 && fs_cyc < 0) fs_cyc = cyc;
        // expected pins for this request, and the layer data it will read
        for (int k = 0; k < NL; k++) lr[k] = cfg_use_x ? {2'b00, ex} : cfg_rgb[k];
        e.de = (mh < 640) && (mv < 480);
        e.hs = !(mh >= 656 && mh < 752);
        e.vs = !(mv >= 490 && mv < 492);
        e.hit = |cfg_alpha;
        if (cfg_alpha[0])      e.lrgb = lr[0];
        else if (cfg_alpha[1]) e.lrgb = lr[1];
        else if (cfg_alpha[2]) e.lrgb = lr[2];
        else if (cfg_alpha[3]) e.lrgb = lr[3];
        else                   e.lrgb = 12'h000;
        e.x = mh;
        q.push_back(e);
        for (int k = 0; k < NL; k++) pend_rgb[k*RW +: RW] = lr[k];
        pend_alpha = cfg_alpha;
        mh++;
        if (mh == 800) begin mh = 0; mv++; if (mv == 525) mv = 0; end
        // pins of the full-size instance
        checks++;
        if (q.size() == 3) begin
            p = q.pop_front();
`ifdef VGA_TEST_PATTERN_EN
            bgv = bar_color(p.x);
`else
            bgv = bg_rgb_i;
`endif
            exp_rgb = (!p.de || !en_i) ? 12'h000 : (p.hit ? p.lrgb : bgv);
            if ({vga_hs_o, vga_vs_o, vga_de_o, vga_rgb_o} !== {p.hs, p.vs, p.de, exp_rgb}) begin
                errors++;
                $display("FAIL pins cyc=%0d got hs=%b vs=%b de=%b rgb=%h want hs=%b vs=%b de=%b rgb=%h",
                    cyc, vga_hs_o, vga_vs_o, vga_de_o, vga_rgb_o, p.hs, p.vs, p.de, exp_rgb);
            end
        end else if ({vga_hs_o, vga_vs_o, vga_de_o, vga_rgb_o} !== {1'b1, 1'b1, 1'b0, 12'h000}) begin
            errors++;
            $display("FAIL pins_fill cyc=%0d got hs=%b vs=%b de=%b rgb=%h want idle",
                cyc, vga_hs_o, vga_vs_o, vga_de_o, vga_rgb_o);
        end
        if (vga_hs_o === 1'b0 && prev_hs === 1'b1 && hs_fall_cyc < 0) hs_fall_cyc = cyc;
        prev_hs = vga_hs_o;
        if (vga_hs_o === 1'b0) hs_low_cnt++;
        if (vga_de_o === 1'b1) de_hi_cnt++;
        if (vga_rgb_o !== 12'h000) rgb_nz_cnt++;
        // stage 0 of the small instance
        sx = (sh < SH_DISP) ? 10'(sh) : 10'h3FF;
        sy = (sv < SV_DISP) ? 10'(sv) : 10'h3FF;
        checks++;
        if ({s_req_x, s_req_y, s_v_sync, s_frame_start} !==
            {sx, sy, !(sv >= SV_DISP + SV_FP && sv < SV_DISP + SV_FP + SV_SYNC), (sh == 0 && sv == 0)}) begin
            errors++;
            $display("FAIL small_stage0 cyc=%0d got x=%0d y=%0d vs=%b fs=%b want x=%0d y=%0d",
                cyc, s_req_x, s_req_y, s_v_sync, s_frame_start, sx, sy);
        end
        sh++;
        if (sh == SH_TOT) begin sh = 0; sv++; if (sv == SV_TOT) sv = 0; end
        if (s_hs === 1'b0) s_hs_low++;
        if (s_vs === 1'b0) s_vs_low++;
        if (s_de === 1'b1) s_de_hi++;
        if (s_frame_start === 1'b1) s_fs_cnt++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    // async reset: outputs must idle immediately, then the model restarts at (0,0)
    task automatic do_reset(input string tag);
        @(negedge clk_vga);
        rst = 1'b1;
        #1;
        checks++;
        if ({req_x_addr_o, req_y_addr_o, v_sync_o, frame_start_o, vga_hs_o, vga_vs_o, vga_de_o, vga_rgb_o} !==
            {10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000}) begin
            errors++;
            $display("FAIL reset_%s got x=%0d y=%0d vsy=%b fs=%b hs=%b vs=%b de=%b rgb=%h want 0 0 1 0 1 1 0 000",
                tag, req_x_addr_o, req_y_addr_o, v_sync_o, frame_start_o, vga_hs_o, vga_vs_o, vga_de_o, vga_rgb_o);
        end
        checks++;
        if ({s_req_x, s_frame_start, s_hs, s_de} !== {10'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_small_%s got x=%0d fs=%b hs=%b de=%b", tag, s_req_x, s_frame_start, s_hs, s_de);
        end
        @(posedge clk_vga);
        @(negedge clk_vga);
        rst = 1'b0;
        layer_rgb_i = '0; layer_alpha_i = '0; pend_rgb = '0; pend_alpha = '0;
        q.delete();
        cyc = 0; mh = 0; mv = 0; sh = 0; sv = 0;
        fs_cyc = -1; hs_fall_cyc = -1; prev_hs = 1'b1;
        hs_low_cnt = 0; de_hi_cnt = 0; rgb_nz_cnt = 0;
        s_hs_low = 0; s_vs_low = 0; s_de_hi = 0; s_fs_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset("power_on");
        step_to(300);
        do_reset("mid_line");
        step_to(1);
        checks++;
        if (fs_cyc !== 1) begin
            errors++;
            $display("FAIL first_frame_start got cycle %0d want 1", fs_cyc);
        end
    endtask

    task automatic test_request_latency();
        cfg_use_x = 1'b1;
        cfg_alpha = 4'b0001;
        step_to(103);
        checks++;
        if (vga_rgb_o !== 12'h064) begin
            errors++;
            $display("FAIL latency_x100 got %h want 064", vga_rgb_o);
        end
        step_to(700);
        checks++;
        if (req_x_addr_o !== 10'd1023) begin
            errors++;
            $display("FAIL blank_req_x got %0d want 1023", req_x_addr_o);
        end
    endtask

    task automatic test_line_timing();
        step_to(810);
        checks++;
        if (hs_fall_cyc - fs_cyc !== 658) begin
            errors++;
            $display("FAIL hs_fall_delay got %0d want 658", hs_fall_cyc - fs_cyc);
        end
        checks++;
        if (hs_low_cnt !== 96) begin
            errors++;
            $display("FAIL hs_low_line0 got %0d want 96", hs_low_cnt);
        end
        checks++;
        if (de_hi_cnt !== 648) begin
            errors++;
            $display("FAIL de_high_count got %0d want 648", de_hi_cnt);
        end
    endtask

    task automatic test_priority();
        cfg_use_x = 1'b0;
        cfg_rgb[0] = 12'hF00; cfg_rgb[1] = 12'h00F; cfg_rgb[2] = 12'h0F0; cfg_rgb[3] = 12'h333;
        cfg_alpha = 4'b0101;
        step_to(cyc + 4);
        checks++;
        if (vga_rgb_o !== 12'hF00) begin
            errors++;
            $display("FAIL prio_0101 got %h want F00", vga_rgb_o);
        end
        cfg_alpha = 4'b0100;
        step_to(cyc + 4);
        checks++;
        if (vga_rgb_o !== 12'h0F0) begin
            errors++;
            $display("FAIL prio_0100 got %h want 0F0", vga_rgb_o);
        end
        cfg_alpha = 4'b0000;
        bg_rgb_i = 12'h00F;
        step_to(cyc + 4);
        checks++;
`ifdef VGA_TEST_PATTERN_EN
        if (vga_rgb_o !== 12'hFFF) begin
            errors++;
            $display("FAIL prio_bg got %h want FFF", vga_rgb_o);
        end
`else
        if (vga_rgb_o !== 12'h00F) begin
            errors++;
            $display("FAIL prio_bg got %h want 00F", vga_rgb_o);
        end
`endif
    endtask

    task automatic test_enable();
        cfg_alpha = 4'b0001;
        cfg_rgb[0] = 12'hABC;
        en_i = 1'b0;
        step_to(cyc + 2);
        hs_low_cnt = 0;
        rgb_nz_cnt = 0;
        step_to(1586);
        checks++;
        if (rgb_nz_cnt !== 0) begin
            errors++;
            $display("FAIL en_off_rgb got %0d nonzero pixels want 0", rgb_nz_cnt);
        end
        checks++;
        if (hs_low_cnt !== 96) begin
            errors++;
            $display("FAIL en_off_hs got %0d low cycles want 96", hs_low_cnt);
        end
        en_i = 1'b1;
        cfg_alpha = 4'b0000;
    endtask

    task automatic test_background();
        logic [RW-1:0] want [3];
        int            at [3];
        bg_rgb_i = 12'h5A3;
        at[0] = 1603; at[1] = 1688; at[2] = 2242;
`ifdef VGA_TEST_PATTERN_EN
        want[0] = 12'hFFF; want[1] = 12'hFF0; want[2] = 12'h000;
`else
        want[0] = 12'h5A3; want[1] = 12'h5A3; want[2] = 12'h5A3;
`endif
        for (int i = 0; i < 3; i++) begin
            step_to(at[i]);
            checks++;
            if (vga_rgb_o !== want[i]) begin
                errors++;
                $display("FAIL background_%0d got %h want %h", i, vga_rgb_o, want[i]);
            end
        end
    endtask

    task automatic test_small_frames();
        do_reset("small");
        step_to(2 * SH_TOT * SV_TOT);
        checks++;
        if (s_hs_low !== 2 * SH_SYNC * SV_TOT) begin
            errors++;
            $display("FAIL small_hs_low got %0d want %0d", s_hs_low, 2 * SH_SYNC * SV_TOT);
        end
        checks++;
        if (s_vs_low !== 2 * SV_SYNC * SH_TOT) begin
            errors++;
            $display("FAIL small_vs_low got %0d want %0d", s_vs_low, 2 * SV_SYNC * SH_TOT);
        end
        checks++;
        if (s_de_hi !== 2 * SH_DISP * SV_DISP) begin
            errors++;
            $display("FAIL small_de_high got %0d want %0d", s_de_hi, 2 * SH_DISP * SV_DISP);
        end
        checks++;
        if (s_fs_cnt !== 2) begin
            errors++;
            $display("FAIL small_frame_starts got %0d want 2", s_fs_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        en_i = 1'b1;
        bg_rgb_i = 12'h000;
        layer_rgb_i = '0;
        layer_alpha_i = '0;
        pend_rgb = '0;
        pend_alpha = '0;
        cfg_use_x = 1'b0;
        cfg_alpha = 4'b0000;
        for (int k = 0; k < NL; k++) cfg_rgb[k] = 12'h000;
        test_reset();
        test_request_latency();
        test_line_timing();
        test_priority();
        test_enable();
        test_background();
        test_small_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
